// File: rtl/hazard5_muldiv_iter_if.sv
// rtl/hazard5_muldiv_iter_if.sv - request/result handshake bundle for the iterative mul/div unit
interface hazard5_muldiv_iter_if #(
    parameter int XLEN = 32
);
    logic [2:0]      op;
    logic            op_vld;
    logic            op_rdy;
    logic            op_kill;
    logic [XLEN-1:0] op_a;
    logic [XLEN-1:0] op_b;
    logic [XLEN-1:0] result_h;
    logic [XLEN-1:0] result_l;
    logic            result_vld;
    logic            result_rdy;

    modport master (
        output op, op_vld, op_kill, op_a, op_b, result_rdy,
        input  op_rdy, result_h, result_l, result_vld
    );

    modport slave (
        input  op, op_vld, op_kill, op_a, op_b, result_rdy,
        output op_rdy, result_h, result_l, result_vld
    );
endinterface

// File: rtl/hazard5_muldiv_iter.sv
// rtl/hazard5_muldiv_iter.sv - iterative RV32M/RV64M multiply/divide, UNROLL bits per cycle
module hazard5_muldiv_iter #(
    parameter int XLEN       = 32,
    parameter int UNROLL     = 1,
    parameter int EARLY_TERM = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    hazard5_muldiv_iter_if.slave  bus
);
    localparam int STEPS = XLEN / UNROLL;
    localparam int CW    = $clog2(STEPS + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PREP,
        S_RUN,
        S_FIX,
        S_DONE
    } state_t;

    state_t state, state_nxt;

    logic [2:0]        op_q;
    logic [XLEN-1:0]   a_q, b_q;
    logic [2*XLEN-1:0] acc, mcand;
    logic [XLEN-1:0]   mplier;
    logic [CW-1:0]     cnt;
    logic              neg_h, neg_l;
    logic [XLEN-1:0]   res_h, res_l;

    logic              is_div, a_signed, b_signed, sign_a, sign_b;
    logic [XLEN-1:0]   abs_a, abs_b;
    logic              op_rdy_c, accept, early_exit, last_step;
    logic [2*XLEN-1:0] acc_s, mcand_s;
    logic [XLEN-1:0]   mplier_s;
    logic [XLEN:0]     rem_sh, diff;

    always_comb begin
        is_div   = op_q[2];
        a_signed = (op_q == 3'd1) || (op_q == 3'd2) || (op_q == 3'd4) || (op_q == 3'd6);
        b_signed = (op_q == 3'd1) || (op_q == 3'd4) || (op_q == 3'd6);
        sign_a   = a_signed & a_q[XLEN-1];
        sign_b   = b_signed & b_q[XLEN-1];
        abs_a    = sign_a ? -a_q : a_q;
        abs_b    = sign_b ? -b_q : b_q;
    end

    assign op_rdy_c       = (state == S_IDLE) || ((state == S_DONE) && bus.result_rdy);
    assign accept         = op_rdy_c && bus.op_vld && !bus.op_kill;
    assign bus.op_rdy     = op_rdy_c;
    assign bus.result_vld = (state == S_DONE);
    assign bus.result_h   = res_h;
    assign bus.result_l   = res_l;

    // Multiply: multiplicand shifts left into a 2*XLEN accumulator, so an early
    // exit needs no realignment. Divide: acc = {remainder, dividend/quotient}.
    always_comb begin
        acc_s    = acc;
        mcand_s  = mcand;
        mplier_s = mplier;
        rem_sh   = '0;
        diff     = '0;
        for (int i = 0; i < UNROLL; i++) begin
            if (is_div) begin
                rem_sh = {acc_s[2*XLEN-1:XLEN], acc_s[XLEN-1]};
                diff   = rem_sh - {1'b0, mcand_s[XLEN-1:0]};
                if (!diff[XLEN]) begin
                    acc_s = {diff[XLEN-1:0], acc_s[XLEN-2:0], 1'b1};
                end else begin
                    acc_s = {rem_sh[XLEN-1:0], acc_s[XLEN-2:0], 1'b0};
                end
            end else begin
                if (mplier_s[0]) begin
                    acc_s = acc_s + mcand_s;
                end
                mcand_s  = mcand_s << 1;
                mplier_s = mplier_s >> 1;
            end
        end
    end

    assign early_exit = (EARLY_TERM != 0) && !is_div && (mplier_s == '0);
    assign last_step  = (cnt == CW'(STEPS - 1));

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (accept) state_nxt = S_PREP;
            // Divide by zero skips RUN; FIX then passes the preset result through.
            S_PREP: state_nxt = (is_div && (b_q == '0)) ? S_FIX : S_RUN;
            S_RUN:  if (last_step || early_exit) state_nxt = S_FIX;
            S_FIX:  state_nxt = S_DONE;
            S_DONE: if (bus.result_rdy) state_nxt = accept ? S_PREP : S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
        if (bus.op_kill) begin
            state_nxt = S_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= S_IDLE;
            op_q   <= '0;
            a_q    <= '0;
            b_q    <= '0;
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            cnt    <= '0;
            neg_h  <= 1'b0;
            neg_l  <= 1'b0;
            res_h  <= '0;
            res_l  <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                op_q <= bus.op;
                a_q  <= bus.op_a;
                b_q  <= bus.op_b;
            end
            case (state)
                S_PREP: begin
                    cnt    <= '0;
                    mplier <= abs_b;
                    if (is_div) begin
                        mcand <= {{XLEN{1'b0}}, abs_b};
                        if (b_q == '0) begin
                            acc   <= {a_q, {XLEN{1'b1}}};
                            neg_h <= 1'b0;
                            neg_l <= 1'b0;
                        end else begin
                            acc   <= {{XLEN{1'b0}}, abs_a};
                            neg_h <= sign_a;
                            neg_l <= sign_a ^ sign_b;
                        end
                    end else begin
                        acc   <= '0;
                        mcand <= {{XLEN{1'b0}}, abs_a};
                        neg_h <= sign_a ^ sign_b;
                        neg_l <= sign_a ^ sign_b;
                    end
                end
                S_RUN: begin
                    acc    <= acc_s;
                    mcand  <= mcand_s;
                    mplier <= mplier_s;
                    cnt    <= cnt + CW'(1);
                end
                S_FIX: begin
                    if (is_div) begin
                        res_h <= neg_h ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
                        res_l <= neg_l ? -acc[XLEN-1:0] : acc[XLEN-1:0];
                    end else begin
                        {res_h, res_l} <= neg_l ? -acc : acc;
                    end
                end
                default: ;
            endcase
            if (bus.op_kill) begin
                res_h <= '0;
                res_l <= '0;
            end
        end
    end
endmodule

// File: tb/tb_hazard5_muldiv_iter.sv
// tb/tb_hazard5_muldiv_iter.sv - directed and randomized checks over several UNROLL/EARLY_TERM builds
module tb_hazard5_muldiv_iter;
    localparam int N = 5;

    logic        clk;
    logic [2:0]  t_op   [N];
    logic [31:0] t_a    [N];
    logic [31:0] t_b    [N];
    logic        t_vld  [N];
    logic        t_kill [N];
    logic        t_rrdy [N];
    logic        t_rst  [N];
    logic        o_rdy  [N];
    logic        o_vld  [N];
    logic [31:0] o_h    [N];
    logic [31:0] o_l    [N];

    int total = 0;
    int bad   = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    genvar g;
    generate
        for (g = 0; g < N; g++) begin : g_dut
            localparam int GU  = (g == 2) ? 2 : (g == 3) ? 4 : (g == 4) ? 8 : 1;
            localparam int GET = (g == 1) ? 0 : 1;
            hazard5_muldiv_iter_if #(.XLEN(32)) bus ();
            assign bus.op         = t_op[g];
            assign bus.op_vld     = t_vld[g];
            assign bus.op_kill    = t_kill[g];
            assign bus.op_a       = t_a[g];
            assign bus.op_b       = t_b[g];
            assign bus.result_rdy = t_rrdy[g];
            assign o_rdy[g]       = bus.op_rdy;
            assign o_vld[g]       = bus.result_vld;
            assign o_h[g]         = bus.result_h;
            assign o_l[g]         = bus.result_l;
            hazard5_muldiv_iter #(.XLEN(32), .UNROLL(GU), .EARLY_TERM(GET)) dut (
                .clk (clk),
                .rst (t_rst[g]),
                .bus (bus)
            );
        end
    endgenerate

    function automatic int steps_of(input int idx);
        return (idx == 2) ? 16 : (idx == 3) ? 8 : (idx == 4) ? 4 : 32;
    endfunction

    // Reference results from plain integer arithmetic, {high/remainder, low/quotient}.
    function automatic logic [63:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint      xa, xb;
        logic [63:0] p;
        logic [31:0] q, r;
        xa = (op == 3'd1 || op == 3'd2) ? longint'($signed(a)) : longint'({32'b0, a});
        xb = (op == 3'd1) ? longint'($signed(b)) : longint'({32'b0, b});
        p  = 64'(xa * xb);
        q  = 32'hFFFF_FFFF;
        r  = a;
        if (op < 3'd4) return p;
        if (b != 32'd0) begin
            if (op == 3'd4 || op == 3'd6) begin
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                    q = a;
                    r = 32'd0;
                end else begin
                    q = 32'($signed(a) / $signed(b));
                    r = 32'($signed(a) % $signed(b));
                end
            end else begin
                q = a / b;
                r = a % b;
            end
        end
        return {r, q};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic issue(input int idx, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        int w;
        w = 0;
        t_op[idx]  = op;
        t_a[idx]   = a;
        t_b[idx]   = b;
        t_vld[idx] = 1'b1;
        #1;
        while (!o_rdy[idx] && w < 400) begin
            @(negedge clk);
            #1;
            w++;
        end
        chk("issue_rdy", 64'(o_rdy[idx]), 64'd1);
        @(posedge clk);
        @(negedge clk);
        t_vld[idx]  = 1'b0;
        t_rrdy[idx] = 1'b0;
        t_op[idx]   = 3'($urandom);
        t_a[idx]    = $urandom;
        t_b[idx]    = $urandom;
    endtask

    task automatic wait_result(input int idx, output int lat, output logic [63:0] res);
        lat = 0;
        while (!o_vld[idx] && lat < 400) begin
            @(negedge clk);
            lat++;
        end
        res = {o_h[idx], o_l[idx]};
        chk("result_seen", 64'(o_vld[idx]), 64'd1);
    endtask

    task automatic ack(input int idx);
        t_rrdy[idx] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        t_rrdy[idx] = 1'b0;
    endtask

    task automatic run(input int idx, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       output int lat, output logic [63:0] res);
        issue(idx, op, a, b);
        wait_result(idx, lat, res);
        ack(idx);
    endtask

    task automatic watch_idle(input string tag, input int idx);
        logic seen;
        seen = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (o_vld[idx]) seen = 1'b1;
        end
        chk(tag, 64'(seen), 64'd0);
    endtask

    initial begin
        int          lat;
        logic [63:0] res;
        logic [31:0] a, b;

        for (int i = 0; i < N; i++) begin
            t_op[i] = '0; t_a[i] = '0; t_b[i] = '0;
            t_vld[i] = 1'b0; t_kill[i] = 1'b0; t_rrdy[i] = 1'b0; t_rst[i] = 1'b1;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < N; i++) t_rst[i] = 1'b0;

        chk("rst_op_rdy", 64'(o_rdy[0]), 64'd1);
        chk("rst_vld", 64'(o_vld[0]), 64'd0);
        chk("rst_res", {o_h[0], o_l[0]}, 64'd0);

        run(0, 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, res);
        chk("mulhu_max", res, 64'hFFFF_FFFE_0000_0001);
        chk("mulhu_lat", 64'(lat), 64'd34);

        run(0, 3'd1, 32'h8000_0000, 32'h8000_0000, lat, res);
        chk("mulh_minmin", res, 64'h4000_0000_0000_0000);
        run(0, 3'd2, 32'h8000_0000, 32'h8000_0000, lat, res);
        chk("mulhsu_min", res, 64'hC000_0000_0000_0000);

        run(0, 3'd0, 32'd7, 32'd3, lat, res);
        chk("mul_et_val", {32'd0, res[31:0]}, 64'd21);
        chk("mul_et_fast", 64'(lat <= 5), 64'd1);
        run(1, 3'd0, 32'd7, 32'd3, lat, res);
        chk("mul_noet_val", {32'd0, res[31:0]}, 64'd21);
        chk("mul_noet_lat", 64'(lat), 64'd34);

        run(0, 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, lat, res);
        chk("div_ovf", res, 64'h0000_0000_8000_0000);
        chk("div_lat", 64'(lat), 64'd34);
        run(0, 3'd5, 32'h0000_1234, 32'd0, lat, res);
        chk("divu_zero", res, 64'h0000_1234_FFFF_FFFF);
        chk("divu_zero_lat", 64'(lat), 64'd2);
        run(0, 3'd6, 32'hFFFF_FFF9, 32'd2, lat, res);
        chk("rem_neg", {32'd0, res[63:32]}, 64'hFFFF_FFFF);

        // Result held under back-pressure, then a new op taken in the handshake cycle.
        issue(0, 3'd5, 32'd100, 32'd7);
        wait_result(0, lat, res);
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            chk("hold_res", {o_h[0], o_l[0]}, {32'd2, 32'd14});
            chk("hold_vld", 64'(o_vld[0]), 64'd1);
            chk("hold_op_rdy", 64'(o_rdy[0]), 64'd0);
        end
        t_rrdy[0] = 1'b1;
        #1;
        chk("b2b_op_rdy", 64'(o_rdy[0]), 64'd1);
        issue(0, 3'd0, 32'd7, 32'd3);
        wait_result(0, lat, res);
        chk("b2b_val", {32'd0, res[31:0]}, 64'd21);
        chk("b2b_lat", 64'(lat <= 5), 64'd1);
        ack(0);

        issue(0, 3'd4, 32'd1000, 32'd7);
        repeat (5) @(negedge clk);
        t_kill[0] = 1'b1;
        @(negedge clk);
        t_kill[0] = 1'b0;
        chk("kill_vld", 64'(o_vld[0]), 64'd0);
        chk("kill_op_rdy", 64'(o_rdy[0]), 64'd1);
        chk("kill_res", {o_h[0], o_l[0]}, 64'd0);
        watch_idle("kill_no_result", 0);

        t_kill[0] = 1'b1;
        t_vld[0]  = 1'b1;
        @(negedge clk);
        t_kill[0] = 1'b0;
        t_vld[0]  = 1'b0;
        watch_idle("kill_blocks_accept", 0);

        run(0, 3'd0, 32'd7, 32'd3, lat, res);
        issue(0, 3'd4, 32'd1000, 32'd7);
        repeat (5) @(negedge clk);
        t_rst[0] = 1'b1;
        @(negedge clk);
        t_rst[0] = 1'b0;
        chk("rst_mid_vld", 64'(o_vld[0]), 64'd0);
        chk("rst_mid_op_rdy", 64'(o_rdy[0]), 64'd1);
        chk("rst_mid_res", {o_h[0], o_l[0]}, 64'd0);
        watch_idle("rst_mid_no_result", 0);

        for (int u = 0; u < N; u++) begin
            for (int o = 0; o < 8; o++) begin
                for (int k = 0; k < 25; k++) begin
                    a = $urandom;
                    b = $urandom;
                    if (k == 0) b = 32'd0;
                    else if (k == 1) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                    else if (k % 4 == 2) b = b >> $urandom_range(31, 0);
                    else if (k % 4 == 3) a = a >> $urandom_range(31, 0);
                    run(u, 3'(o), a, b, lat, res);
                    chk("rand_val", res, model(3'(o), a, b));
                    if (o >= 4) begin
                        chk("rand_div_lat", 64'(lat), (b == 32'd0) ? 64'd2 : 64'(steps_of(u) + 2));
                    end else if (u == 1) begin
                        chk("rand_mul_lat", 64'(lat), 64'd34);
                    end else begin
                        chk("rand_mul_lat_max", 64'(lat <= steps_of(u) + 2), 64'd1);
                    end
                end
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
